// File: rtl/tdm_demux_pkg.sv
// Shared types and default constants for the TDM demultiplexer.
//   state_t    : framing state (HUNT, COLLECT, EXPECT_SOF)
//   TDM_WIDTH  : default bits per channel sample
//   TDM_NUM_CH : default channels per frame
//   IDX_W      : channel index width for the default channel count
package tdm_pkg;

  localparam int unsigned TDM_WIDTH  = 8;
  localparam int unsigned TDM_NUM_CH = 4;
  localparam int unsigned IDX_W      = $clog2(TDM_NUM_CH);

  typedef enum logic [1:0] {
    HUNT       = 2'd0,
    COLLECT    = 2'd1,
    EXPECT_SOF = 2'd2
  } state_t;

endpackage

// File: rtl/tdm_demux_if.sv
// Stream-in / frame-out handshake bundle of the TDM demultiplexer.
//   in_data/in_valid/in_sof/in_ready : per-beat input stream, sof marks channel 0
//   out_data/out_valid/out_ready     : one assembled frame per transfer,
//                                      channel k at [k*WIDTH +: WIDTH]
// master: the side driving beats and consuming frames; slave: the demultiplexer.
interface tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH  = TDM_WIDTH,
  parameter int unsigned NUM_CH = TDM_NUM_CH
) ();

  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic                    in_sof;
  logic                    in_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_sof,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_sof,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/tdm_demux.sv
// Receive end of an N:1 TDM byte link. Beats arrive one channel per cycle,
// channel 0 flagged by in_sof; each beat is steered into its slot and a
// complete frame is presented on a valid/ready output register.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : tdm_demux_if slave (input stream, output frame)
//   chan_idx    : channel index expected for the next beat
//   sync_err    : one-cycle pulse on an early or missing start-of-frame
//   frame_count : frames delivered, wraps
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH  = TDM_WIDTH,
  parameter int unsigned NUM_CH = TDM_NUM_CH,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tdm_demux_if.slave                bus,
  output logic [$clog2(NUM_CH)-1:0] chan_idx,
  output logic                      sync_err,
  output logic [CNT_W-1:0]          frame_count
);

  localparam int unsigned IdxW = $clog2(NUM_CH);
  // The last channel goes straight to the output register, so only
  // NUM_CH-1 slots need buffering.
  localparam int unsigned BufW = (NUM_CH - 1) * WIDTH;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CH - 1);

  state_t                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [BufW-1:0]         buf_q, buf_d;
  logic [NUM_CH*WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    sync_err_q, sync_err_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic in_ready;
  logic accept;
  logic deliver;
  logic start_frame;

  // Stall only when the final beat would overwrite an undelivered frame;
  // combinational from out_ready so a same-cycle drain lets the beat in.
  assign in_ready = !((state_q == COLLECT) && (idx_q == LastIdx) &&
                      out_valid_q && !bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign deliver  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sync_err_d  = 1'b0;
    count_d     = count_q;
    start_frame = 1'b0;

    if (deliver) begin
      out_valid_d = 1'b0;
      count_d     = count_q + CNT_W'(1);
    end

    if (accept) begin
      unique case (state_q)
        HUNT: begin
          // Beats without sof are discarded silently while hunting.
          if (bus.in_sof) begin
            start_frame = 1'b1;
          end
        end
        COLLECT: begin
          if (bus.in_sof) begin
            // Early sof: abandon the partial frame and restart on this beat.
            sync_err_d  = 1'b1;
            start_frame = 1'b1;
          end else if (idx_q == LastIdx) begin
            // A same-cycle delivery already cleared out_valid_d; this sets it
            // again so back-to-back frames flow without a bubble.
            out_data_d  = {bus.in_data, buf_q};
            out_valid_d = 1'b1;
            idx_d       = '0;
            state_d     = EXPECT_SOF;
          end else begin
            buf_d[int'(idx_q) * WIDTH +: WIDTH] = bus.in_data;
            idx_d = idx_q + IdxW'(1);
          end
        end
        EXPECT_SOF: begin
          if (bus.in_sof) begin
            start_frame = 1'b1;
          end else begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = '0;
        end
      endcase
    end

    if (start_frame) begin
      buf_d[WIDTH-1:0] = bus.in_data;
      idx_d            = IdxW'(1);
      state_d          = COLLECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      idx_q       <= '0;
      buf_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign chan_idx      = idx_q;
  assign sync_err      = sync_err_q;
  assign frame_count   = count_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed, table-driven bench for tdm_demux (WIDTH=8, NUM_CH=4).
module tb_tdm_demux;

  logic        clk;
  logic        rst_n;
  logic [1:0]  chan_idx;
  logic        sync_err;
  logic [15:0] frame_count;

  tdm_demux_if #(.WIDTH(8), .NUM_CH(4)) bus ();

  tdm_demux #(
    .WIDTH (8),
    .NUM_CH(4),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .chan_idx   (chan_idx),
    .sync_err   (sync_err),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic        r;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_se;
    logic [1:0]  e_ci;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic v, input logic s, input logic [7:0] d,
                              input logic r, input logic e_rdy, input logic e_ov,
                              input logic [31:0] e_od, input logic e_se,
                              input logic [1:0] e_ci, input logic [15:0] e_fc);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.r = r;
    t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_od = e_od;
    t.e_se = e_se; t.e_ci = e_ci; t.e_fc = e_fc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven just after a rising edge; in_ready is sampled before
  // the next edge, registered outputs 1 time unit after it.
  task automatic run_vec(input vec_t t, input int i);
    string tag;
    bus.in_valid  = t.v;
    bus.in_sof    = t.s;
    bus.in_data   = t.d;
    bus.out_ready = t.r;
    #2;
    tag = $sformatf("v%0d", i);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(t.e_rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(t.e_ov));
    if (t.e_ov) chk({tag, ".out_data"}, bus.out_data, t.e_od);
    chk({tag, ".sync_err"}, 32'(sync_err), 32'(t.e_se));
    chk({tag, ".chan_idx"}, 32'(chan_idx), 32'(t.e_ci));
    chk({tag, ".frame_count"}, 32'(frame_count), 32'(t.e_fc));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".out_data"}, bus.out_data, 32'd0);
    chk({tag, ".sync_err"}, 32'(sync_err), 32'd0);
    chk({tag, ".chan_idx"}, 32'(chan_idx), 32'd0);
    chk({tag, ".frame_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    //             v  s  d      r  rdy ov od            se ci fc
    // basic frame
    vecs.push_back(mk(1, 1, 8'haa, 1, 1, 0, 32'h0,        0, 1, 0));
    vecs.push_back(mk(1, 0, 8'hbb, 1, 1, 0, 32'h0,        0, 2, 0));
    vecs.push_back(mk(1, 0, 8'hcc, 1, 1, 0, 32'h0,        0, 3, 0));
    vecs.push_back(mk(1, 0, 8'hdd, 1, 1, 1, 32'hddccbbaa, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 32'h0,        0, 0, 1));
    // missing sof after a frame, then hunting drops 11/22
    vecs.push_back(mk(1, 0, 8'h55, 1, 1, 0, 32'h0,        1, 0, 1));
    vecs.push_back(mk(1, 0, 8'h11, 1, 1, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h22, 1, 1, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 1, 8'haa, 1, 1, 0, 32'h0,        0, 1, 1));
    vecs.push_back(mk(1, 0, 8'hbb, 1, 1, 0, 32'h0,        0, 2, 1));
    vecs.push_back(mk(1, 0, 8'hcc, 1, 1, 0, 32'h0,        0, 3, 1));
    vecs.push_back(mk(1, 0, 8'hdd, 1, 1, 1, 32'hddccbbaa, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 32'h0,        0, 0, 2));
    // early sof
    vecs.push_back(mk(1, 1, 8'haa, 1, 1, 0, 32'h0,        0, 1, 2));
    vecs.push_back(mk(1, 0, 8'hbb, 1, 1, 0, 32'h0,        0, 2, 2));
    vecs.push_back(mk(1, 1, 8'h01, 1, 1, 0, 32'h0,        1, 1, 2));
    vecs.push_back(mk(1, 0, 8'h02, 1, 1, 0, 32'h0,        0, 2, 2));
    vecs.push_back(mk(1, 0, 8'h03, 1, 1, 0, 32'h0,        0, 3, 2));
    vecs.push_back(mk(1, 0, 8'h04, 1, 1, 1, 32'h04030201, 0, 0, 2));
    // backpressure: frame held, last beat stalls until out_ready
    vecs.push_back(mk(1, 1, 8'haa, 0, 1, 1, 32'h04030201, 0, 1, 2));
    vecs.push_back(mk(1, 0, 8'hbb, 0, 1, 1, 32'h04030201, 0, 2, 2));
    vecs.push_back(mk(1, 0, 8'hcc, 0, 1, 1, 32'h04030201, 0, 3, 2));
    vecs.push_back(mk(1, 0, 8'hdd, 0, 0, 1, 32'h04030201, 0, 3, 2));
    vecs.push_back(mk(1, 0, 8'hdd, 1, 1, 1, 32'hddccbbaa, 0, 0, 3));
    vecs.push_back(mk(1, 1, 8'h01, 0, 1, 1, 32'hddccbbaa, 0, 1, 3));
    vecs.push_back(mk(1, 0, 8'h02, 0, 1, 1, 32'hddccbbaa, 0, 2, 3));
    vecs.push_back(mk(1, 0, 8'h03, 0, 1, 1, 32'hddccbbaa, 0, 3, 3));
    vecs.push_back(mk(1, 0, 8'h04, 0, 0, 1, 32'hddccbbaa, 0, 3, 3));
    vecs.push_back(mk(1, 0, 8'h04, 1, 1, 1, 32'h04030201, 0, 0, 4));
    vecs.push_back(mk(0, 1, 8'hff, 1, 1, 0, 32'h0,        0, 0, 5));
    // sof/data ignored while in_valid=0: still expecting sof
    vecs.push_back(mk(1, 0, 8'h77, 1, 1, 0, 32'h0,        1, 0, 5));

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Asynchronous reset mid-frame, between clock edges.
    run_vec(mk(1, 1, 8'haa, 1, 1, 0, 32'h0, 0, 1, 5), 100);
    run_vec(mk(1, 0, 8'hbb, 1, 1, 0, 32'h0, 0, 2, 5), 101);
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec(mk(1, 1, 8'haa, 0, 1, 0, 32'h0,        0, 1, 0), 110);
    run_vec(mk(1, 0, 8'hbb, 0, 1, 0, 32'h0,        0, 2, 0), 111);
    run_vec(mk(1, 0, 8'hcc, 0, 1, 0, 32'h0,        0, 3, 0), 112);
    run_vec(mk(1, 0, 8'hdd, 0, 1, 1, 32'hddccbbaa, 0, 0, 0), 113);
    run_vec(mk(0, 0, 8'h00, 1, 1, 0, 32'h0,        0, 0, 1), 114);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of a 4:1 byte multiplexer link: accepts a time-division-multiplexed stream of bytes, one channel per beat, with a start-of-frame marker on channel 0.
- Steers each beat into its channel's slot of a collection buffer.
- Presents each completed frame, one word per channel, on a valid/ready output register.
- Detects framing errors and counts delivered frames.

Parameters:
- WIDTH, 8, bits per channel sample.
- NUM_CH, 4, channels per frame; legal range 2..16.
- CNT_W, 16, width of frame counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  sample for current channel.
- in_valid  input  1  in_data valid this cycle.
- in_sof  input  1  beat is channel 0 (start of frame); qualified by in_valid.
- in_ready  output  1  block accepts beat this cycle.
- out_data  output  NUM_CH*WIDTH  frame; channel k at bits [k*WIDTH +: WIDTH].
- out_valid  output  1  out_data holds an undelivered frame.
- out_ready  input  1  downstream accepts frame.
- chan_idx  output  clog2(NUM_CH)  channel index expected for next beat.
- sync_err  output  1  one-cycle pulse on framing error.
- frame_count  output  CNT_W  frames delivered (out_valid && out_ready), wraps modulo 2^CNT_W.

Behaviour:
- Accept: beat accepted when in_valid && in_ready at rising edge.
- Reset (asynchronous, any time, including mid-frame): state=HUNT, chan_idx=0, out_valid=0, out_data=0, collection buffer=0, sync_err=0, frame_count=0. A partial frame is lost.
- HUNT:
  - in_ready=1.
  - Accepted beat without in_sof: dropped, no error.
  - Accepted beat with in_sof: stored to slot 0, chan_idx=1, go to COLLECT.
- COLLECT, beat with in_sof:
  - Early SOF: partial frame abandoned, sync_err=1 for one cycle.
  - Beat stored to slot 0, chan_idx=1, stay in COLLECT.
- COLLECT, beat without in_sof, chan_idx < NUM_CH-1: stored to slot chan_idx, chan_idx increments.
- COLLECT, beat without in_sof, chan_idx == NUM_CH-1 (last beat):
  - Buffer plus this beat loads out_data; out_valid=1 from the next cycle. Latency: last beat accepted at edge N, frame visible after edge N.
  - chan_idx=0, go to EXPECT_SOF.
- EXPECT_SOF:
  - in_ready=1.
  - Beat with in_sof: handled as in HUNT.
  - Beat without in_sof: sync_err=1 for one cycle, beat dropped, go to HUNT.
- Backpressure:
  - in_ready is low only in COLLECT with chan_idx==NUM_CH-1 && out_valid && !out_ready.
  - in_ready is combinational from out_ready; this path is intentional.
- Simultaneous delivery and last beat: out_valid && out_ready on the same edge as a last-beat accept loads the new frame with out_valid staying 1. No bubble, no loss.
- Delivery with no new frame: out_valid && out_ready clears out_valid and increments frame_count.
- out_data is stable while out_valid && !out_ready.
- in_data and in_sof are ignored when in_valid=0. chan_idx never exceeds NUM_CH-1.

Decomposition:
- Package tdm_pkg:
  - state enum {HUNT, COLLECT, EXPECT_SOF}, 2 bits.
  - default constants TDM_WIDTH=8, TDM_NUM_CH=4.
  - localparam IDX_W=clog2(NUM_CH).
- No sub-module; single always_ff for state/buffer/output register, combinational in_ready.

Test Plan:
- Reset mid-frame: send sof aa, bb, assert rst_n=0 asynchronously between edges -> all outputs zero immediately; then frame aa,bb,cc,dd -> out_data=ddccbbaa, frame_count=1.
- Basic frame, out_ready=1: sof aa, bb, cc, dd -> out_valid high one cycle after dd accepted, out_data=0xddccbbaa, sync_err never pulses, frame_count=1.
- Hunt: beats 11, 22 without sof, then sof aa, bb, cc, dd -> 11/22 dropped, out_data=0xddccbbaa, no sync_err.
- Early SOF: sof aa, bb, sof 01, 02, 03, 04 -> sync_err pulses once on second sof; out_data=0x04030201.
- Backpressure: out_ready=0, two back-to-back frames (aa..dd, 01..04) -> in_ready drops while 04 is presented, first frame held stable; raise out_ready -> 0xddccbbaa delivered, then 0x04030201 the next cycle with out_valid continuous; frame_count=2.
- Missing SOF after a frame: frame aa..dd then beat 55 without sof -> sync_err pulse, 55 dropped, state HUNT; chan_idx=0.
